// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier. One iteration per CALC cycle,
// WIDTH-cycle latency from the accepting edge to the done pulse.
//
// Parameter:
//   WIDTH     operand width in bits (2..64)
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, accepted only when busy=0
//   is_signed 1 = two's-complement operands (only with SEQ_MUL_SIGNED_EN)
//   a, b      multiplicand / multiplier, sampled on the accepting edge
//   busy      high while an iteration sequence is running
//   done      one-cycle pulse after the product register is written
//   product   2*WIDTH-bit result register
//
// Build option:
//   SEQ_MUL_SIGNED_EN  when defined, is_signed selects signed operation
//                      (magnitudes multiplied, result negated when the
//                      operand signs differ); when undefined, is_signed is
//                      ignored and all operands are unsigned.

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic               neg_q;
    logic               accept;
    logic               last;

    // A request is taken in IDLE and also in DONE (back-to-back issue).
    assign accept = start && (state != CALC);
    assign last   = (cnt == CW'(1));

    // -------------------------------------------------------------
    // Operand conditioning
    // -------------------------------------------------------------
`ifdef SEQ_MUL_SIGNED_EN
    logic a_neg;
    logic b_neg;

    assign a_neg  = is_signed & a[WIDTH-1];
    assign b_neg  = is_signed & b[WIDTH-1];
    // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign neg_in = a_neg ^ b_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (accept) begin
            neg_q <= neg_in;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag  = a;
    assign b_mag  = b;
    assign neg_in = 1'b0;
    assign neg_q  = neg_in;
`endif

    // -------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;
    assign result  = neg_q ? -acc_sum : acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            // Final iteration: the sum being formed is the full product.
            if (last) begin
                product <= result;
            end
        end
    end

    // -------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? CALC : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks for seq_multiplier (WIDTH=32).
// Signed expectations follow SEQ_MUL_SIGNED_EN when it is defined.

module tb_seq_multiplier;

    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            is_signed;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int checks;
    int errors;
    int cyc;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Issue one request, count busy cycles and done pulses.
    task automatic do_mul(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic sg, output logic [63:0] p,
                          output int bcyc, output int dcnt);
        @(negedge clk);
        a = ia;
        b = ib;
        is_signed = sg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcyc = 0;
        dcnt = 0;
        while (busy === 1'b1 && bcyc < 100) begin
            bcyc++;
            @(posedge clk);
            #1;
        end
        if (done === 1'b1) dcnt++;
        p = product;
        @(posedge clk);
        #1;
        if (done === 1'b1) dcnt++;
    endtask

    logic [63:0] p;
    logic [63:0] exp;
    logic [63:0] ea;
    logic [63:0] eb;
    int bc;
    int dc;
    int n;
    int t1;
    int t2;
    logic sg;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // unsigned max x max
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, bc, dc);
        chk("umax_product", p, 64'hFFFF_FFFE_0000_0001);
        chk("umax_busy_cycles", 64'(bc), 64'd32);
        chk("umax_done_pulses", 64'(dc), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("product_hold", product, 64'hFFFF_FFFE_0000_0001);

        // zero operand and unit operands
        do_mul(32'h0, 32'hFFFF_FFFF, 1'b0, p, bc, dc);
        chk("zero_a", p, 64'd0);
        do_mul(32'h1, 32'h1, 1'b0, p, bc, dc);
        chk("one_one", p, 64'd1);
        do_mul(32'h1234_5678, 32'h0000_0010, 1'b0, p, bc, dc);
        chk("shift16", p, 64'h0000_0001_2345_6780);

        // signed: 3 x -2
        do_mul(32'd3, 32'hFFFF_FFFE, 1'b1, p, bc, dc);
`ifdef SEQ_MUL_SIGNED_EN
        chk("s_3_m2", p, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        chk("s_3_m2", p, 64'h0000_0002_FFFF_FFFA);
`endif
        chk("s_3_m2_busy", 64'(bc), 64'd32);

        // signed: min x min (same bits for both builds)
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, p, bc, dc);
        chk("s_min_min", p, 64'h4000_0000_0000_0000);

        // signed -1 x -1 / is_signed ignored when feature is off
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, bc, dc);
`ifdef SEQ_MUL_SIGNED_EN
        chk("s_m1_m1", p, 64'd1);
`else
        chk("s_m1_m1", p, 64'hFFFF_FFFE_0000_0001);
`endif

        // signed -7 x 5 = -35
        do_mul(32'hFFFF_FFF9, 32'd5, 1'b1, p, bc, dc);
`ifdef SEQ_MUL_SIGNED_EN
        chk("s_m7_5", p, 64'hFFFF_FFFF_FFFF_FFDD);
`else
        chk("s_m7_5", p, 64'h0000_0004_FFFF_FFDD);
`endif

        // start re-asserted with new operands during CALC
        @(negedge clk);
        a = 32'd5;
        b = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'd9;
        b = 32'd9;
        is_signed = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        #6;
        wait_done(n);
        chk("ignore_done_seen", 64'(done), 64'd1);
        chk("ignore_product", product, 64'd35);
        dc = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dc++;
        end
        chk("ignore_extra_done", 64'(dc), 64'd0);

        // asynchronous reset 10 cycles into CALC
        @(negedge clk);
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dc++;
        end
        chk("rst_no_done", 64'(dc), 64'd0);

        // back-to-back: start held in the DONE cycle
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3000;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        t1 = cyc;
        chk("b2b_first", product, 64'd3000000);
        a = 32'hFFFF_FFFF;
        b = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept_busy", 64'(busy), 64'd1);
        wait_done(n);
        t2 = cyc;
        chk("b2b_second", product, 64'h0000_0001_FFFF_FFFE);
        chk("b2b_spacing", 64'(t2 - t1), 64'd33);

        // random pairs against a 64-bit reference product
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = 32'h8000_0000;
            if (i % 13 == 0) rb = 32'h0;
            sg = 1'($urandom_range(0, 1));
`ifdef SEQ_MUL_SIGNED_EN
            ea = sg ? {{32{ra[31]}}, ra} : {32'h0, ra};
            eb = sg ? {{32{rb[31]}}, rb} : {32'h0, rb};
`else
            ea = {32'h0, ra};
            eb = {32'h0, rb};
`endif
            exp = ea * eb;
            do_mul(ra, rb, sg, p, bc, dc);
            chk("random", p, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only on a clk edge where busy=0.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking product valid.
REQ-010 SHALL have port product  output  2*WIDTH  result register.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on accepted start; CALC->DONE after WIDTH iterations; DONE->IDLE next edge, or DONE->CALC if start asserted in DONE.
REQ-012 SHALL latch a, b, is_signed on the accepting edge E0 and load iteration counter with WIDTH.
REQ-013 SHALL perform one radix-2 shift-add iteration per CALC cycle (edges E1..E(WIDTH)), accumulating into a 2*WIDTH-bit register.
REQ-014 SHALL, in signed mode, multiply magnitudes of a and b and negate the result at completion when exactly one operand is negative.
REQ-015 SHALL write product on edge E(WIDTH) and assert done for exactly the one cycle following that edge (latency WIDTH cycles).
REQ-016 SHALL assert busy from E0 until edge E(WIDTH); busy=0 in IDLE and DONE.
REQ-017 SHALL ignore start while busy=1; latched operands and counter unaffected.
REQ-018 SHALL hold product stable from done until the edge completing the next multiplication.
REQ-019 SHALL produce the exact 2*WIDTH-bit result for all inputs, incl. zero operands and signed -2^(WIDTH-1) x -2^(WIDTH-1) = 2^(2*WIDTH-2) (no overflow).
REQ-020 SHALL change input sampling only on accepted start; changes to a/b/is_signed during CALC have no effect.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, product=0, counter and accumulator to 0, independent of clk.
REQ-022 SHALL abort any in-progress multiplication on reset with no done pulse; first start accepted on first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL support macro SEQ_MUL_SIGNED_EN: when defined, is_signed behaves per REQ-005/REQ-014.
REQ-024 SHALL, when SEQ_MUL_SIGNED_EN is undefined, ignore is_signed, treat all operands as unsigned, and omit magnitude/negation logic; timing unchanged.

Verification (WIDTH=32, SEQ_MUL_SIGNED_EN defined unless noted)
REQ-025 SHALL cover: unsigned a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle -> busy 32 cycles, done pulse once, product=0xFFFFFFFE00000001.
REQ-026 SHALL cover: signed a=3, b=0xFFFFFFFE (-2) -> product=0xFFFFFFFFFFFFFFFA; signed a=b=0x80000000 -> product=0x4000000000000000.
REQ-027 SHALL cover: start re-asserted with new operands during CALC -> ignored, product matches first operands, exactly one done.
REQ-028 SHALL cover: rst_n pulsed low at cycle 10 of CALC -> busy=0, done=0, product=0 immediately; no done afterward until new start.
REQ-029 SHALL cover: back-to-back start asserted in DONE cycle -> second accepted, done pulses spaced WIDTH+1 cycles.
REQ-030 SHALL cover: macro undefined, is_signed=1, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (unsigned); plus 1000 random pairs vs. reference a*b.
